// File: rtl/axi_rd_slave.sv
// AXI4-Lite read-channel responder (AR/R only) over a word-addressed RAM with a preload port.
// Optional: define AXI_RD_SLAVE_RAND_DELAY_EN to add an LFSR-driven 0..7 cycle extra latency per read.
module axi_rd_slave #(
  parameter int          DATA_W  = 64,
  parameter int          DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [63:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF   = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic [15:0]       cnt;
  logic [15:0]       load_cnt;
  logic [63:0]       offset;
  logic [IDX_W-1:0]  hit_idx;
  logic              hit_err;
  logic              unused_lsbs;

  // Byte offsets below the word size select nothing; the whole word is returned.
  assign offset      = araddr - BASE;
  assign hit_idx     = offset[OFF +: IDX_W];
  assign hit_err     = (araddr < BASE) || (|offset[63:OFF+IDX_W]);
  assign unused_lsbs = ^offset[OFF-1:0];

`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign load_cnt = 16'(LATENCY - 1) + {13'd0, lfsr[2:0]};
`else
  assign load_cnt = 16'(LATENCY - 1);
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (state)
      IDLE: begin
        arready = 1'b1;
        if (arvalid) state_next = WAIT;
      end
      WAIT: begin
        if (cnt == 16'd0) state_next = RESP;
      end
      RESP: begin
        rvalid = 1'b1;
        if (rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The RAM is sampled on the last WAIT cycle; a same-edge preload lands afterwards.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      idx   <= '0;
      err   <= 1'b0;
      cnt   <= 16'd0;
      rdata <= '0;
      rresp <= 2'b00;
    end else if (state == IDLE && arvalid) begin
      idx <= hit_idx;
      err <= hit_err;
      cnt <= load_cnt;
    end else if (state == WAIT) begin
      if (cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else begin
        rdata <= err ? '0 : mem[idx];
        rresp <= err ? 2'b11 : 2'b00;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

endmodule

// File: tb/tb_axi_rd_slave.sv
// Randomized self-checking bench for axi_rd_slave against an address-arithmetic reference model.
// Latency bounds widen to LATENCY..LATENCY+7 when AXI_RD_SLAVE_RAND_DELAY_EN is defined.
module tb_axi_rd_slave;

  localparam int          DATA_W  = 64;
  localparam int          DEPTH   = 4096;
  localparam logic [63:0] BASE    = 64'h8000_0000;
  localparam int          LATENCY = 2;
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
  localparam int LAT_MIN = LATENCY;
  localparam int LAT_MAX = LATENCY + 7;
`else
  localparam int LAT_MIN = LATENCY;
  localparam int LAT_MAX = LATENCY;
`endif

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [63:0]       araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready = 1'b0;
  logic              ld_en = 1'b0;
  logic [11:0]       ld_idx = '0;
  logic [DATA_W-1:0] ld_data = '0;

  int errors = 0;
  int checks = 0;
  logic [63:0] model_mem [DEPTH];

  axi_rd_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: anything below BASE or past the last word decodes to DECERR with zero data.
  function automatic logic [65:0] model_read(input logic [63:0] a);
    logic [63:0] w;
    if (a < BASE) return {2'b11, 64'd0};
    w = (a - BASE) / 64'(DATA_W / 8);
    if (w >= 64'(DEPTH)) return {2'b11, 64'd0};
    return {2'b00, model_mem[w[11:0]]};
  endfunction

  task automatic preload(input int idx, input logic [63:0] d);
    @(negedge ACLK);
    ld_en = 1'b1; ld_idx = 12'(idx); ld_data = d;
    @(negedge ACLK);
    ld_en = 1'b0;
    model_mem[idx] = d;
  endtask

  // Issues one read with rready high throughout; lat = -1 if rvalid never came.
  task automatic issue_read(input logic [63:0] addr, output int lat, output logic [63:0] d,
                            output logic [1:0] resp, output logic ar_low,
                            output logic rv_after, output logic ar_after);
    @(negedge ACLK);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0; araddr = {$urandom, $urandom};
    ar_low = arready;
    lat = 0;
    while (rvalid !== 1'b1 && lat < 40) begin
      @(negedge ACLK);
      lat++;
    end
    if (rvalid !== 1'b1) lat = -1;
    d = rdata; resp = rresp;
    @(negedge ACLK);
    rv_after = rvalid; ar_after = arready;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b expected 1", arready); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b expected 00", rresp); end
    ARESETn = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa;
    preload(0, 64'h1122_3344_5566_7788);
    issue_read(BASE, lat, d, resp, al, rva, aa);
    checks++; if (al !== 1'b0) begin errors++; $display("FAIL basic_arready_low: got %b expected 0", al); end
    checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    checks++; if (d !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL basic_rdata: got %h expected 1122334455667788", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL basic_rresp: got %b expected 00", resp); end
    checks++; if (rva !== 1'b0) begin errors++; $display("FAIL basic_rvalid_drop: got %b expected 0", rva); end
    checks++; if (aa !== 1'b1) begin errors++; $display("FAIL basic_arready_back: got %b expected 1", aa); end
  endtask

  task automatic test_unaligned();
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa;
    preload(5, 64'hDEAD_BEEF_0000_0005);
    issue_read(64'h8000_002B, lat, d, resp, al, rva, aa);
    checks++; if (d !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL unaligned_rdata: got %h expected deadbeef00000005", d); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL unaligned_rresp: got %b expected 00", resp); end
    preload(DEPTH - 1, 64'h0F0F_1234_ABCD_FFFF);
    issue_read(BASE + 64'((DEPTH - 1) * 8 + 7), lat, d, resp, al, rva, aa);
    checks++; if (d !== 64'h0F0F_1234_ABCD_FFFF || resp !== 2'b00) begin errors++; $display("FAIL last_word: got %h/%b expected 0f0f1234abcdffff/00", d, resp); end
  endtask

  task automatic test_decerr();
    logic [63:0] addrs [2];
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa;
    addrs[0] = 64'h7FFF_FFF8;
    addrs[1] = BASE + 64'(DEPTH * 8);
    for (int i = 0; i < 2; i++) begin
      issue_read(addrs[i], lat, d, resp, al, rva, aa);
      checks++; if (d !== 64'd0 || resp !== 2'b11) begin errors++; $display("FAIL decerr_%0d: got %h/%b expected 0/11", i, d, resp); end
      checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL decerr_latency_%0d: got %0d expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX); end
    end
  endtask

  task automatic test_stall();
    int lat; logic [63:0] d0;
    preload(7, 64'hCAFE_0007_1357_9BDF);
    @(negedge ACLK);
    araddr = BASE + 64'd56; arvalid = 1'b1; rready = 1'b0;
    @(negedge ACLK);
    arvalid = 1'b0;
    lat = 0;
    while (rvalid !== 1'b1 && lat < 40) begin @(negedge ACLK); lat++; end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL stall_rvalid_timeout: got %b expected 1", rvalid); end
    d0 = rdata;
    checks++; if (d0 !== 64'hCAFE_0007_1357_9BDF) begin errors++; $display("FAIL stall_rdata: got %h expected cafe000713579bdf", d0); end
    araddr = BASE; arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      checks++;
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: got rvalid=%b rdata=%h arready=%b expected 1/%h/0", k, rvalid, rdata, arready, d0);
      end
    end
    rready = 1'b1;
    @(negedge ACLK);
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL stall_release: got rvalid=%b arready=%b expected 0/1", rvalid, arready); end
    @(negedge ACLK);
    arvalid = 1'b0;
    lat = 0;
    while (rvalid !== 1'b1 && lat < 40) begin @(negedge ACLK); lat++; end
    checks++; if (rvalid !== 1'b1 || rdata !== model_mem[0] || rresp !== 2'b00) begin errors++; $display("FAIL stall_second: got %b/%h/%b expected 1/%h/00", rvalid, rdata, rresp, model_mem[0]); end
    @(negedge ACLK);
  endtask

`ifndef AXI_RD_SLAVE_RAND_DELAY_EN
  // Preload lands on the same edge the RAM is sampled: the old word must come back.
  task automatic test_rbw();
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa;
    preload(9, 64'hAAAA_0000_0000_0009);
    @(negedge ACLK);
    araddr = BASE + 64'd72; arvalid = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0;
    @(negedge ACLK);
    ld_en = 1'b1; ld_idx = 12'd9; ld_data = 64'hBBBB_0000_0000_0009;
    @(negedge ACLK);
    ld_en = 1'b0;
    model_mem[9] = 64'hBBBB_0000_0000_0009;
    checks++; if (rvalid !== 1'b1 || rdata !== 64'hAAAA_0000_0000_0009) begin errors++; $display("FAIL rbw_old: got %b/%h expected 1/aaaa000000000009", rvalid, rdata); end
    @(negedge ACLK);
    issue_read(BASE + 64'd72, lat, d, resp, al, rva, aa);
    checks++; if (d !== 64'hBBBB_0000_0000_0009) begin errors++; $display("FAIL rbw_new: got %h expected bbbb000000000009", d); end
  endtask
`endif

  task automatic test_abort();
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa; int seen_rv;
    @(negedge ACLK);
    araddr = BASE; arvalid = 1'b1; rready = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0;
    #1 ARESETn = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || arready !== 1'b1) begin errors++; $display("FAIL abort_in_reset: got rvalid=%b arready=%b expected 0/1", rvalid, arready); end
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    seen_rv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge ACLK);
      if (rvalid === 1'b1) seen_rv++;
    end
    checks++; if (seen_rv != 0) begin errors++; $display("FAIL abort_no_response: got %0d rvalid cycles expected 0", seen_rv); end
    checks++; if (arready !== 1'b1) begin errors++; $display("FAIL abort_arready: got %b expected 1", arready); end
    issue_read(BASE, lat, d, resp, al, rva, aa);
    checks++; if (d !== model_mem[0] || resp !== 2'b00) begin errors++; $display("FAIL abort_reread: got %h/%b expected %h/00", d, resp, model_mem[0]); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] d; logic [1:0] resp; logic al, rva, aa;
    logic [63:0] addr; logic [65:0] exp; int r; int distinct;
    bit seen [64];
    for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    for (int n = 0; n < 100; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE - 64'(8 * $urandom_range(1, 100));
      else if (r == 1) addr = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 4000));
      else             addr = BASE + 64'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
      exp = model_read(addr);
      issue_read(addr, lat, d, resp, al, rva, aa);
      checks++; if (lat < LAT_MIN || lat > LAT_MAX) begin errors++; $display("FAIL b2b_latency_%0d: got %0d expected %0d..%0d", n, lat, LAT_MIN, LAT_MAX); end
      checks++; if ({resp, d} !== exp) begin errors++; $display("FAIL b2b_data_%0d addr=%h: got %b/%h expected %b/%h", n, addr, resp, d, exp[65:64], exp[63:0]); end
      if (lat >= 0 && lat < 64) seen[lat] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 64; i++) if (seen[i]) distinct++;
`ifdef AXI_RD_SLAVE_RAND_DELAY_EN
    checks++; if (distinct < 4) begin errors++; $display("FAIL b2b_distinct_latencies: got %0d expected >=4", distinct); end
`else
    checks++; if (distinct != 1) begin errors++; $display("FAIL b2b_fixed_latency: got %0d distinct expected 1", distinct); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unaligned();
    test_decerr();
    test_stall();
`ifndef AXI_RD_SLAVE_RAND_DELAY_EN
    test_rbw();
`endif
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
